fetch_ifid_unit: RTL and testbench

//   Consumer end of the load-use stall interface: holds the PC and the IF/ID pipeline register.

---
 rtl/fetch_ifid_unit.sv | 95 +++++++++
 tb/tb_fetch_ifid_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_unit.sv
// rtl/fetch_ifid_unit.sv - PC and IF/ID register with stall, redirect/flush and HALT freeze
// Optional single-step debug freeze is enabled by defining STEP_MODE_EN.
module fetch_ifid_unit #(
  parameter int               NBITS      = 32,
  parameter logic [NBITS-1:0] PC_RESET   = '0,
  parameter logic [NBITS-1:0] HALT_INSTR = {NBITS{1'b1}},
  parameter logic [NBITS-1:0] NOP_INSTR  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_pc,
  input  logic             stall_ID,
  input  logic             branch_taken,
  input  logic [NBITS-1:0] branch_target,
  input  logic             jump,
  input  logic [NBITS-1:0] jump_target,
  input  logic [NBITS-1:0] imem_instr,
`ifdef STEP_MODE_EN
  input  logic             debug_mode,
  input  logic             step,
`endif
  output logic [NBITS-1:0] pc,
  output logic [NBITS-1:0] IF_ID_instr,
  output logic [NBITS-1:0] IF_ID_pc4,
  output logic             IF_ID_valid,
  output logic             halted
);

  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             freeze;
  logic [NBITS-1:0] pc_plus4;

`ifdef STEP_MODE_EN
  assign freeze = debug_mode & ~step;
`else
  assign freeze = 1'b0;
`endif

  assign pc_plus4 = pc_q + NBITS'(4);

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (freeze) begin
      // debugger holds the whole pipeline, redirects included
    end else if (branch_taken || jump) begin
      pc_d     = branch_taken ? branch_target : jump_target;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (halted_q) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (write_pc && !stall_ID) begin
      instr_d = imem_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      if (imem_instr == HALT_INSTR) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      instr_q  <= NOP_INSTR;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc4   = pc4_q;
  assign IF_ID_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ifid_unit.sv
// tb/tb_fetch_ifid_unit.sv - directed and random checks of fetch_ifid_unit against a reference model
module tb_fetch_ifid_unit;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1, write_pc = 1'b0, stall_ID = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, imem_instr = '0;
  logic [31:0] pc, IF_ID_instr, IF_ID_pc4;
  logic        IF_ID_valid, halted;
`ifdef STEP_MODE_EN
  logic        debug_mode = 1'b0, step = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted;
  logic [31:0] mem [64];

  fetch_ifid_unit dut (
    .clk(clk), .reset(reset), .write_pc(write_pc), .stall_ID(stall_ID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_instr(imem_instr),
`ifdef STEP_MODE_EN
    .debug_mode(debug_mode), .step(step),
`endif
    .pc(pc), .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4),
    .IF_ID_valid(IF_ID_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, step the model by the fetch rules, compare all outputs.
  task automatic apply(input logic rst, input logic wpc, input logic st,
                       input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic [31:0] ins);
    logic frz;
    reset = rst; write_pc = wpc; stall_ID = st;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt; imem_instr = ins;
    frz = 1'b0;
`ifdef STEP_MODE_EN
    frz = debug_mode && !step;
`endif
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
    end else if (frz) begin
    end else if (br || j) begin
      m_pc = br ? bt : jt; m_instr = 0; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (wpc && !st) begin
      m_instr = ins; m_pc4 = m_pc + 4; m_valid = 1;
      if (ins == HALT) m_halted = 1;
      else m_pc = m_pc + 4;
    end
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("instr", IF_ID_instr, m_instr);
    check_eq("valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
    check_eq("halted", {31'b0, halted}, {31'b0, m_halted});
    if (m_valid) check_eq("pc4", IF_ID_pc4, m_pc4);
  endtask

  task automatic adv(input logic [31:0] ins);
    apply(0, 1, 0, 0, 0, 0, 0, ins);
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
    #1;
    apply(1, 1, 0, 0, 0, 0, 0, 32'h2001_0005);
    check_eq("rst_pc4", IF_ID_pc4, 32'h0);
    check_eq("rst_valid", {31'b0, IF_ID_valid}, 32'h0);

    adv(32'h2001_0005);
    check_eq("t1_pc", pc, 32'h4);
    check_eq("t1_instr", IF_ID_instr, 32'h2001_0005);
    check_eq("t1_pc4", IF_ID_pc4, 32'h4);
    adv(32'h0000_1111);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h0000_2222);
    check_eq("t2_stall_pc", pc, 32'h8);
    check_eq("t2_stall_instr", IF_ID_instr, 32'h0000_1111);
    apply(0, 1, 1, 0, 0, 0, 0, 32'h0000_2222);
    check_eq("t2_mismatch_pc", pc, 32'h8);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0000_2222);
    check_eq("t2_mismatch2_pc", pc, 32'h8);
    adv(32'h0000_2222);
    check_eq("t2_resume_pc", pc, 32'hC);

    apply(0, 0, 1, 1, 32'h40, 0, 0, 32'h3333);
    check_eq("t3_pc", pc, 32'h40);
    check_eq("t3_instr", IF_ID_instr, 32'h0);

    apply(0, 1, 0, 0, 0, 1, 32'h10, 32'h4444);
    adv(HALT);
    check_eq("t4_instr", IF_ID_instr, HALT);
    check_eq("t4_halted", {31'b0, halted}, 32'h1);
    check_eq("t4_pc", pc, 32'h10);
    adv(HALT);
    check_eq("t4_drain", {31'b0, IF_ID_valid}, 32'h0);
    apply(0, 1, 0, 1, 32'h20, 1, 32'h80, 32'h5555);
    check_eq("t4_br_pc", pc, 32'h20);
    check_eq("t4_unhalt", {31'b0, halted}, 32'h0);

    apply(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    adv(32'h6666);
    check_eq("t5_wrap_pc", pc, 32'h0);
    check_eq("t5_wrap_pc4", IF_ID_pc4, 32'h0);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h7777);
    apply(1, 0, 1, 0, 0, 0, 0, 32'h7777);
    check_eq("t5_rst_pc", pc, 32'h0);
    check_eq("t5_rst_instr", IF_ID_instr, 32'h0);

`ifdef STEP_MODE_EN
    adv(32'h1);
    debug_mode = 1'b1; step = 1'b0;
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 1, 32'h100, 0, 0, 32'h2);
    check_eq("t6_frozen_pc", pc, 32'h4);
    step = 1'b1;
    apply(0, 1, 0, 1, 32'h100, 0, 0, 32'h2);
    check_eq("t6_step_pc", pc, 32'h100);
    step = 1'b0;
    apply(0, 1, 0, 0, 0, 0, 0, 32'h2);
    check_eq("t6_hold_pc", pc, 32'h100);
    debug_mode = 1'b0;
`endif

    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int n = 0; n < 3000; n++) begin
      logic r, w, s, b, jj;
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 9) == 0);
      b  = ($urandom_range(0, 15) == 0);
      jj = ($urandom_range(0, 15) == 0);
`ifdef STEP_MODE_EN
      debug_mode = ($urandom_range(0, 7) == 0);
      step = $urandom_range(0, 1);
`endif
      apply(r, w, s, b, $urandom, jj, $urandom, mem[m_pc[7:2]]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
